master_tile_sequencer: RTL and testbench
========================================

Name: master_tile_sequencer

Overview:
- Parametrised tile-level controller for the systolic multiply path.
- Walks a full output matrix as a grid of width_height x width_height submatrices, with an intermediate (K) tile loop per output tile.
- For each step it pulses the weight FIFO/array loader, then enables the data-memory/calc engine, and drives accumulator-table tile coordinates plus an accumulate/overwrite flag.
- Sits between the instruction decoder and the weight_fifo/data_mem_calc control blocks.

Parameters:
- width_height, 16: systolic array edge length.
- max_out_width_height, 128: maximum output matrix edge.
- TILE_W, $clog2(max_out_width_height/width_height) = 3: tile index/count width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a tiled multiply; sampled only in IDLE.
- num_tile_rows  in  TILE_W  output tile rows minus 1.
- num_tile_cols  in  TILE_W  output tile columns minus 1.
- num_tile_k  in  TILE_W  intermediate tiles minus 1.
- weight_fifo_arr_done  in  1  weight load complete (pulse or level).
- data_mem_calc_done  in  1  calc pass complete (pulse or level).
- weight_fifo_arr_en  out  1  one-cycle weight-load request.
- data_mem_calc_en  out  1  level; calc engine enabled.
- accum_table_submat_row_out  out  TILE_W  current output tile row.
- accum_table_submat_col_out  out  TILE_W  current output tile column.
- tile_k  out  TILE_W  current intermediate tile index.
- accum_add  out  1  0 = overwrite accumulator tile (k==0); 1 = add.
- fifo_ready  out  1  weights consumed into array; FIFO may be refilled.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last tile's calc completes.

Behaviour:
- All outputs are registered.
- On reset, state goes to IDLE and every output and index register is 0.
- Reset takes priority over all inputs. Mid-operation reset aborts with no done pulse.
- States and transitions:
  - IDLE: on start, latch the three counts, clear row/col/k, go to LOAD_W.
  - LOAD_W: weight_fifo_arr_en=1 for exactly this one cycle, then go to WAIT_W.
  - WAIT_W: wait for weight_fifo_arr_done, then go to CALC.
  - CALC: data_mem_calc_en=1 and fifo_ready=1 for the whole state. On data_mem_calc_done:
    - if last tile, go to FIN;
    - otherwise advance the indices and go to LOAD_W.
  - FIN: done=1 for one cycle, then go to IDLE.
- Latency: start to weight_fifo_arr_en is 1 cycle. weight_fifo_arr_done to data_mem_calc_en is 1 cycle. Final data_mem_calc_done to done is 1 cycle.
- Loop order: k innermost, then col, then row. Each index wraps to 0 when it equals its latched count, carrying into the next loop.
- Last tile means row, col and k all equal their latched counts.
- accum_add = (tile_k != 0), updated together with the indices.
- Tile-coordinate outputs are stable from LOAD_W through the end of CALC.
- start while busy is ignored. Count inputs are not re-sampled after latching.
- A done input arriving in the wrong state is ignored; it is not remembered, except as noted under PREFETCH_EN.
- All counts 0 means a single tile: LOAD_W, WAIT_W, CALC, FIN, with accum_add=0.
- Maximum configuration is 8x8x8 = 512 tiles. Indices never exceed their latched counts.

Optional Feature:
- Macro: MASTER_TILE_SEQ_PREFETCH_EN.
- When defined:
  - On entering CALC for a non-last tile, weight_fifo_arr_en pulses once for the next tile (overlap with calc).
  - A weight_fifo_arr_done seen during CALC sets a w_ready flag.
  - On data_mem_calc_done with w_ready=1, go directly to CALC with advanced indices. This drops data_mem_calc_en for one cycle, then re-raises it, and clears w_ready.
  - On data_mem_calc_done with w_ready=0, go to WAIT_W.
  - w_ready clears on reset and in IDLE.
- When undefined: strictly serial load-then-calc as described above, with no w_ready register.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/LOAD_W/WAIT_W/CALC/FIN (3-bit);
  - TILE_W derivation;
  - the width_height and max_out_width_height defaults.
- One natural sub-module, tile_index_counter: a three-level nested wrap counter with inputs clear/advance/counts and outputs indices/last/k_zero.

Test Plan:
- Counts 0/0/0, start: weight_fifo_arr_en cycle 1; done returned 3 cycles later gives data_mem_calc_en; calc_done gives done pulse the next cycle; accum_add=0 throughout.
- Counts rows=1, cols=1, k=2: 12 weight-load pulses. Coordinate sequence (0,0,k0..2), (0,1,...), (1,0,...), (1,1,...). accum_add is 0 only at k=0. A single done at the end.
- start asserted during CALC, plus spurious weight_fifo_arr_done and data_mem_calc_done in IDLE: no state change, no extra pulses.
- Reset asserted in WAIT_W of tile 5 of an 8-tile job: next cycle all outputs 0, busy=0, no done. A new start then restarts at (0,0,0).
- Maximum counts 7/7/7 with immediate done responses: exactly 512 weight pulses; last coordinates (7,7,7); done once.
- With MASTER_TILE_SEQ_PREFETCH_EN, k=1: second weight pulse occurs in the first cycle of CALC. Weight done during CALC, then calc_done, gives CALC again after a single-cycle data_mem_calc_en low gap, with no LOAD_W/WAIT_W.

Source files
------------

// File: rtl/master_tile_sequencer_pkg.sv
// Shared types and defaults for the tile-level multiply sequencer.
// State encoding, array geometry defaults and the tile-index width derivation.
package master_tile_sequencer_pkg;

    localparam int WIDTH_HEIGHT         = 16;
    localparam int MAX_OUT_WIDTH_HEIGHT = 128;

    // Index width needed to count output tiles along one matrix edge.
    function automatic int tile_width(input int max_out, input int edge_len);
        return (max_out / edge_len > 1) ? $clog2(max_out / edge_len) : 1;
    endfunction

    localparam int TILE_W = tile_width(MAX_OUT_WIDTH_HEIGHT, WIDTH_HEIGHT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        WAIT_W = 3'd2,
        CALC   = 3'd3,
        FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/master_tile_sequencer_tile_index_counter.sv
// Three-level nested wrap counter (k innermost, then column, then row).
// Reports when the current tile is the last one and whether k is zero.
module tile_index_counter #(
    parameter int TILE_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [TILE_W-1:0] count_row,
    input  logic [TILE_W-1:0] count_col,
    input  logic [TILE_W-1:0] count_k,
    output logic [TILE_W-1:0] row,
    output logic [TILE_W-1:0] col,
    output logic [TILE_W-1:0] k,
    output logic              last,
    output logic              k_zero
);

    logic [TILE_W-1:0] row_next, col_next, k_next;
    logic              k_wrap, col_wrap;
    logic              k_nonzero;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        k_wrap   = (k == count_k);
        col_wrap = (col == count_col);
        k_next   = k_wrap ? '0 : k + 1'b1;
        col_next = col;
        row_next = row;
        if (k_wrap) begin
            col_next = col_wrap ? '0 : col + 1'b1;
            if (col_wrap) begin
                row_next = (row == count_row) ? '0 : row + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row       <= '0;
            col       <= '0;
            k         <= '0;
            k_nonzero <= 1'b0;
        end else if (advance) begin
            row       <= row_next;
            col       <= col_next;
            k         <= k_next;
            k_nonzero <= (k_next != '0);
        end
    end

    assign last   = (row == count_row) && (col == count_col) && (k == count_k);
    assign k_zero = ~k_nonzero;

endmodule

// File: rtl/master_tile_sequencer.sv
// Tile-level controller: walks output tiles with an inner K loop, issuing weight loads then calc passes.
// Optional weight prefetch overlapping calc is enabled with MASTER_TILE_SEQ_PREFETCH_EN.
module master_tile_sequencer
    import master_tile_sequencer_pkg::*;
#(
    parameter int width_height         = WIDTH_HEIGHT,
    parameter int max_out_width_height = MAX_OUT_WIDTH_HEIGHT,
    parameter int TILE_W               = tile_width(max_out_width_height, width_height)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tile_rows,
    input  logic [TILE_W-1:0] num_tile_cols,
    input  logic [TILE_W-1:0] num_tile_k,
    input  logic              weight_fifo_arr_done,
    input  logic              data_mem_calc_done,
    output logic              weight_fifo_arr_en,
    output logic              data_mem_calc_en,
    output logic [TILE_W-1:0] accum_table_submat_row_out,
    output logic [TILE_W-1:0] accum_table_submat_col_out,
    output logic [TILE_W-1:0] tile_k,
    output logic              accum_add,
    output logic              fifo_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_next;
    logic [TILE_W-1:0] cnt_row, cnt_col, cnt_k;
    logic              clear, advance, last, k_zero, calc_finished;
    logic              weight_en_next, calc_en_next;

`ifdef MASTER_TILE_SEQ_PREFETCH_EN
    logic w_ready, w_ready_next, w_seen, w_avail;

    // A done in the cycle the prefetch request is issued belongs to the previous load.
    assign w_seen  = (state_q == CALC) && data_mem_calc_en && !weight_fifo_arr_en && weight_fifo_arr_done;
    assign w_avail = w_ready || w_seen;
`endif

    // Calc completion only counts while the engine is actually enabled.
    assign calc_finished = (state_q == CALC) && data_mem_calc_en && data_mem_calc_done;

    tile_index_counter #(.TILE_W(TILE_W)) u_index (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .advance   (advance),
        .count_row (cnt_row),
        .count_col (cnt_col),
        .count_k   (cnt_k),
        .row       (accum_table_submat_row_out),
        .col       (accum_table_submat_col_out),
        .k         (tile_k),
        .last      (last),
        .k_zero    (k_zero)
    );

    always_comb begin
        state_next = state_q;
        clear      = 1'b0;
        advance    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                clear      = 1'b1;
                state_next = LOAD_W;
            end
            LOAD_W: state_next = WAIT_W;
            WAIT_W: if (weight_fifo_arr_done) state_next = CALC;
            CALC: if (calc_finished) begin
                if (last) begin
                    state_next = FIN;
                end else begin
                    advance = 1'b1;
`ifdef MASTER_TILE_SEQ_PREFETCH_EN
                    state_next = w_avail ? CALC : WAIT_W;
`else
                    state_next = LOAD_W;
`endif
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        weight_en_next = (state_next == LOAD_W);
        calc_en_next   = (state_next == CALC) && !advance;
`ifdef MASTER_TILE_SEQ_PREFETCH_EN
        // Request the next tile's weights as an enabled calc pass begins, unless nothing follows.
        if ((state_next == CALC) && !last && ((state_q != CALC) || !data_mem_calc_en)) begin
            weight_en_next = 1'b1;
        end
        w_ready_next = w_ready;
        if (state_q == IDLE || calc_finished) begin
            w_ready_next = 1'b0;
        end else if (w_seen) begin
            w_ready_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            cnt_row            <= '0;
            cnt_col            <= '0;
            cnt_k              <= '0;
            weight_fifo_arr_en <= 1'b0;
            data_mem_calc_en   <= 1'b0;
            fifo_ready         <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
`ifdef MASTER_TILE_SEQ_PREFETCH_EN
            w_ready            <= 1'b0;
`endif
        end else begin
            state_q            <= state_next;
            weight_fifo_arr_en <= weight_en_next;
            data_mem_calc_en   <= calc_en_next;
            fifo_ready         <= (state_next == CALC);
            busy               <= (state_next != IDLE);
            done               <= (state_next == FIN);
            if (clear) begin
                cnt_row <= num_tile_rows;
                cnt_col <= num_tile_cols;
                cnt_k   <= num_tile_k;
            end
`ifdef MASTER_TILE_SEQ_PREFETCH_EN
            w_ready <= w_ready_next;
`endif
        end
    end

    assign accum_add = ~k_zero;

endmodule

// File: tb/tb_master_tile_sequencer.sv
// Directed self-checking bench for master_tile_sequencer (serial build, or prefetch build when
// MASTER_TILE_SEQ_PREFETCH_EN is defined).
module tb_master_tile_sequencer;

    localparam int TILE_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [TILE_W-1:0] num_tile_rows = '0;
    logic [TILE_W-1:0] num_tile_cols = '0;
    logic [TILE_W-1:0] num_tile_k = '0;
    logic              weight_fifo_arr_done = 1'b0;
    logic              data_mem_calc_done = 1'b0;
    logic              weight_fifo_arr_en, data_mem_calc_en, accum_add, fifo_ready, busy, done;
    logic [TILE_W-1:0] row_out, col_out, tile_k;

    int checks = 0;
    int errors = 0;
    int w_pulses = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    master_tile_sequencer dut (
        .clk                        (clk),
        .reset                      (reset),
        .start                      (start),
        .num_tile_rows              (num_tile_rows),
        .num_tile_cols              (num_tile_cols),
        .num_tile_k                 (num_tile_k),
        .weight_fifo_arr_done       (weight_fifo_arr_done),
        .data_mem_calc_done         (data_mem_calc_done),
        .weight_fifo_arr_en         (weight_fifo_arr_en),
        .data_mem_calc_en           (data_mem_calc_en),
        .accum_table_submat_row_out (row_out),
        .accum_table_submat_col_out (col_out),
        .tile_k                     (tile_k),
        .accum_add                  (accum_add),
        .fifo_ready                 (fifo_ready),
        .busy                       (busy),
        .done                       (done)
    );

    always @(negedge clk) begin
        if (weight_fifo_arr_en === 1'b1) w_pulses++;
        if (done === 1'b1) done_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"}, weight_fifo_arr_en, 0);
        check({tag, "_cen"}, data_mem_calc_en, 0);
        check({tag, "_row"}, row_out, 0);
        check({tag, "_col"}, col_out, 0);
        check({tag, "_k"}, tile_k, 0);
        check({tag, "_accum"}, accum_add, 0);
        check({tag, "_fifo_ready"}, fifo_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic set_counts(input int nr, input int nc, input int nk);
        num_tile_rows = TILE_W'(nr);
        num_tile_cols = TILE_W'(nc);
        num_tile_k    = TILE_W'(nk);
    endtask

    // One serial tile: weight pulse, one-cycle done reply, calc, calc done.
    task automatic do_tile(input int r, input int c, input int k);
        int n;
        n = 0;
        while (weight_fifo_arr_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("weight_pulse", weight_fifo_arr_en, 1);
        check("load_row", row_out, r);
        check("load_col", col_out, c);
        check("load_k", tile_k, k);
        check("load_accum_add", accum_add, (k != 0) ? 1 : 0);
        check("load_busy", busy, 1);
        step();
        check("weight_pulse_width", weight_fifo_arr_en, 0);
        weight_fifo_arr_done = 1'b1;
        step();
        weight_fifo_arr_done = 1'b0;
        check("calc_en", data_mem_calc_en, 1);
        check("fifo_ready", fifo_ready, 1);
        check("calc_row", row_out, r);
        check("calc_col", col_out, c);
        check("calc_k", tile_k, k);
        data_mem_calc_done = 1'b1;
        step();
        data_mem_calc_done = 1'b0;
        check("calc_en_drop", data_mem_calc_en, 0);
    endtask

    task automatic run_job(input int nr, input int nc, input int nk);
        int w0, d0;
        set_counts(nr, nc, nk);
        w0 = w_pulses;
        d0 = done_pulses;
        start = 1'b1;
        step();
        start = 1'b0;
        set_counts(0, 0, 0);
        for (int r = 0; r <= nr; r++)
            for (int c = 0; c <= nc; c++)
                for (int k = 0; k <= nk; k++)
                    do_tile(r, c, k);
        check("job_done_pulse", done, 1);
        check("job_fin_busy", busy, 1);
        step();
        check("job_done_clear", done, 0);
        check("job_idle_busy", busy, 0);
        check("job_weight_count", w_pulses - w0, (nr + 1) * (nc + 1) * (nk + 1));
        check("job_done_count", done_pulses - d0, 1);
    endtask

    initial begin
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check_all_zero("idle");

`ifdef MASTER_TILE_SEQ_PREFETCH_EN
        set_counts(0, 0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("pf_first_pulse", weight_fifo_arr_en, 1);
        step();
        weight_fifo_arr_done = 1'b1;
        step();
        weight_fifo_arr_done = 1'b0;
        check("pf_calc_en", data_mem_calc_en, 1);
        check("pf_prefetch_pulse", weight_fifo_arr_en, 1);
        check("pf_k0", tile_k, 0);
        step();
        check("pf_prefetch_width", weight_fifo_arr_en, 0);
        weight_fifo_arr_done = 1'b1;
        step();
        weight_fifo_arr_done = 1'b0;
        check("pf_still_calc", data_mem_calc_en, 1);
        data_mem_calc_done = 1'b1;
        step();
        data_mem_calc_done = 1'b0;
        check("pf_gap_cen", data_mem_calc_en, 0);
        check("pf_gap_wen", weight_fifo_arr_en, 0);
        check("pf_gap_k", tile_k, 1);
        check("pf_gap_accum", accum_add, 1);
        check("pf_gap_busy", busy, 1);
        step();
        check("pf_reraise_cen", data_mem_calc_en, 1);
        check("pf_last_no_pulse", weight_fifo_arr_en, 0);
        data_mem_calc_done = 1'b1;
        step();
        data_mem_calc_done = 1'b0;
        check("pf_done", done, 1);
        step();
        check("pf_idle", busy, 0);
        check("pf_weight_count", w_pulses, 2);
        check("pf_done_count", done_pulses, 1);
`else
        // Single tile, slow weight reply, start during CALC ignored.
        set_counts(0, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("single_wen", weight_fifo_arr_en, 1);
        check("single_busy", busy, 1);
        check("single_accum", accum_add, 0);
        step();
        check("single_wen_low", weight_fifo_arr_en, 0);
        step();
        step();
        check("single_wait_cen", data_mem_calc_en, 0);
        check("single_wait_busy", busy, 1);
        weight_fifo_arr_done = 1'b1;
        step();
        weight_fifo_arr_done = 1'b0;
        check("single_cen", data_mem_calc_en, 1);
        check("single_fifo_ready", fifo_ready, 1);
        check("single_calc_accum", accum_add, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_start_cen", data_mem_calc_en, 1);
        check("busy_start_wen", weight_fifo_arr_en, 0);
        check("busy_start_done", done, 0);
        data_mem_calc_done = 1'b1;
        step();
        data_mem_calc_done = 1'b0;
        check("single_done", done, 1);
        check("single_done_cen", data_mem_calc_en, 0);
        check("single_done_accum", accum_add, 0);
        step();
        check("single_done_clear", done, 0);
        check("single_idle", busy, 0);

        // Spurious done inputs in IDLE.
        weight_fifo_arr_done = 1'b1;
        data_mem_calc_done = 1'b1;
        step();
        weight_fifo_arr_done = 1'b0;
        data_mem_calc_done = 1'b0;
        check_all_zero("spurious");
        step();
        check_all_zero("spurious_after");
        check("single_weight_count", w_pulses, 1);
        check("single_done_count", done_pulses, 1);

        // Abort an 8-tile job in WAIT_W of tile 5 (0,1,0).
        set_counts(0, 1, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) do_tile(0, 0, k);
        check("abort_tile5_wen", weight_fifo_arr_en, 1);
        check("abort_tile5_col", col_out, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("abort");
        step();
        step();
        check("abort_no_done", done_pulses, 1);
        check("abort_idle", busy, 0);

        run_job(1, 1, 2);
        run_job(7, 7, 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
